lsu_align: RTL and testbench

LSU_ALIGN -- requirements
Module: lsu_align

---
 rtl/lsu_align.sv | 176 +++++++++++++++++
 tb/tb_lsu_align.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_align.sv
// Load/store alignment unit: turns one ex-stage memory request into one or
// two 8-byte-aligned memory beats, merges split load data and sign/zero
// extends the result for write-back.
module lsu_align #(
    parameter int unsigned MISALIGN_SPLIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    input  logic        is_load_i,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [63:0] addr_i,
    input  logic [63:0] st_data_i,
    input  logic [4:0]  rd_waddr_i,
    output logic        ren_o,
    output logic        wen_o,
    output logic [63:0] raddr_o,
    output logic [63:0] waddr_o,
    output logic [63:0] wdata_o,
    output logic [7:0]  wmask_o,
    input  logic [63:0] rdata_i,
    output logic        busy_o,
    output logic        misalign_o,
    output logic        ld_valid_o,
    output logic [63:0] ld_data_o,
    output logic [4:0]  ld_rd_o
);

    typedef enum logic [1:0] {IDLE, B0, B1, CAP} state_t;

    state_t      state;
    logic [63:0] addr_q;
    logic [63:0] data_q;
    logic [63:0] lo_q;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;
    logic        load_q;
    logic        split_q;

    function automatic logic [3:0] size_of(input logic [1:0] sz);
        case (sz)
            2'd0:    return 4'd1;
            2'd1:    return 4'd2;
            2'd2:    return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [63:0] extend(input logic [2:0] f3, input logic [63:0] raw);
        case (f3)
            3'b000:  return {{56{raw[7]}}, raw[7:0]};
            3'b001:  return {{48{raw[15]}}, raw[15:0]};
            3'b010:  return {{32{raw[31]}}, raw[31:0]};
            3'b100:  return {56'b0, raw[7:0]};
            3'b101:  return {48'b0, raw[15:0]};
            3'b110:  return {32'b0, raw[31:0]};
            default: return raw;
        endcase
    endfunction

    logic          accept;
    logic [2:0]    off_in;
    logic [2:0]    off_q;
    logic          split_in;
    logic [7:0]    mask_b0;
    logic [7:0]    mask_b1;
    logic [63:0]   wdata_b0;
    logic [63:0]   wdata_b1;
    logic [127:0]  beats;
    logic [63:0]   ld_raw;

    // Request qualification and per-beat data/strobe shaping
    always_comb begin
        accept   = req_valid_i && (is_load_i != is_store_i) && (funct3_i != 3'b111);
        off_in   = addr_i[2:0];
        off_q    = addr_q[2:0];
        split_in = ({1'b0, off_in} + size_of(funct3_i[1:0])) > 4'd8;
        mask_b0  = 8'({8'b0, size_mask(funct3_i[1:0])} << off_in);
        mask_b1  = 8'(({8'b0, size_mask(f3_q[1:0])} << off_q) >> 8);
        wdata_b0 = st_data_i << {off_in, 3'b000};
        // Only used when split, so off_q is never 0 here
        wdata_b1 = data_q >> (7'd64 - {1'b0, off_q, 3'b000});
        beats    = split_q ? {rdata_i, lo_q} : {64'b0, rdata_i};
        ld_raw   = 64'(beats >> {off_q, 3'b000});
    end

    assign busy_o = (state != IDLE);

    // Sequencer: accepts a request, issues one or two beats, returns load data
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ren_o      <= 1'b0;
            wen_o      <= 1'b0;
            raddr_o    <= '0;
            waddr_o    <= '0;
            wdata_o    <= '0;
            wmask_o    <= '0;
            misalign_o <= 1'b0;
            ld_valid_o <= 1'b0;
            ld_data_o  <= '0;
            ld_rd_o    <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            lo_q       <= '0;
            f3_q       <= '0;
            rd_q       <= '0;
            load_q     <= 1'b0;
            split_q    <= 1'b0;
        end else begin
            ren_o      <= 1'b0;
            wen_o      <= 1'b0;
            wmask_o    <= '0;
            misalign_o <= 1'b0;
            ld_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= addr_i;
                        data_q  <= st_data_i;
                        f3_q    <= funct3_i;
                        rd_q    <= rd_waddr_i;
                        load_q  <= is_load_i;
                        split_q <= split_in;
                        if (split_in && MISALIGN_SPLIT == 0) begin
                            misalign_o <= 1'b1;
                        end else begin
                            state   <= B0;
                            ren_o   <= is_load_i;
                            wen_o   <= is_store_i;
                            raddr_o <= {addr_i[63:3], 3'b000};
                            waddr_o <= {addr_i[63:3], 3'b000};
                            wdata_o <= wdata_b0;
                            wmask_o <= mask_b0;
                        end
                    end
                end
                B0: begin
                    if (split_q) begin
                        state   <= B1;
                        ren_o   <= load_q;
                        wen_o   <= !load_q;
                        raddr_o <= {addr_q[63:3] + 61'd1, 3'b000};
                        waddr_o <= {addr_q[63:3] + 61'd1, 3'b000};
                        wdata_o <= wdata_b1;
                        wmask_o <= mask_b1;
                    end else begin
                        state <= load_q ? CAP : IDLE;
                    end
                end
                B1: begin
                    lo_q  <= rdata_i;
                    state <= load_q ? CAP : IDLE;
                end
                CAP: begin
                    ld_data_o  <= extend(f3_q, ld_raw);
                    ld_rd_o    <= rd_q;
                    ld_valid_o <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_align.sv
// Self-checking bench for lsu_align: directed scenarios plus randomized
// loads/stores checked against a byte-addressed reference memory.
module tb_lsu_align;

    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam int          NW   = 33;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i, is_load_i, is_store_i;
    logic [2:0]  funct3_i;
    logic [63:0] addr_i, st_data_i;
    logic [4:0]  rd_waddr_i;
    logic        ren_o, wen_o;
    logic [63:0] raddr_o, waddr_o, wdata_o;
    logic [7:0]  wmask_o;
    logic [63:0] rdata_i = '0;
    logic        busy_o, misalign_o, ld_valid_o;
    logic [63:0] ld_data_o;
    logic [4:0]  ld_rd_o;

    logic        ren0, wen0, busy0, mis0, ldv0;
    logic [63:0] raddr0, waddr0, wdata0, ldd0;
    logic [7:0]  wmask0;
    logic [4:0]  ldrd0;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [63:0] dut_mem [0:NW-1];
    logic [7:0]  ref_mem [0:8*NW-1];
    logic [63:0] pend = '0;

    lsu_align #(.MISALIGN_SPLIT(1)) dut (
        .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .is_load_i(is_load_i),
        .is_store_i(is_store_i), .funct3_i(funct3_i), .addr_i(addr_i),
        .st_data_i(st_data_i), .rd_waddr_i(rd_waddr_i), .ren_o(ren_o), .wen_o(wen_o),
        .raddr_o(raddr_o), .waddr_o(waddr_o), .wdata_o(wdata_o), .wmask_o(wmask_o),
        .rdata_i(rdata_i), .busy_o(busy_o), .misalign_o(misalign_o),
        .ld_valid_o(ld_valid_o), .ld_data_o(ld_data_o), .ld_rd_o(ld_rd_o)
    );

    lsu_align #(.MISALIGN_SPLIT(0)) dut_nosplit (
        .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .is_load_i(is_load_i),
        .is_store_i(is_store_i), .funct3_i(funct3_i), .addr_i(addr_i),
        .st_data_i(st_data_i), .rd_waddr_i(rd_waddr_i), .ren_o(ren0), .wen_o(wen0),
        .raddr_o(raddr0), .waddr_o(waddr0), .wdata_o(wdata0), .wmask_o(wmask0),
        .rdata_i(rdata_i), .busy_o(busy0), .misalign_o(mis0),
        .ld_valid_o(ldv0), .ld_data_o(ldd0), .ld_rd_o(ldrd0)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        logic [63:0] d;
        d = a - BASE;
        if (d < 64'(8 * NW)) return dut_mem[int'(d >> 3)];
        return {$urandom, $urandom};
    endfunction

    // Memory: read data appears one cycle after ren_o; writes honour wmask_o
    always @(negedge clk) begin
        logic [63:0] d;
        rdata_i = pend;
        pend = ren_o ? mem_rd(raddr_o) : {$urandom, $urandom};
        if (wen_o) begin
            d = waddr_o - BASE;
            if (d < 64'(8 * NW)) begin
                for (int b = 0; b < 8; b++)
                    if (wmask_o[b]) dut_mem[int'(d >> 3)][8*b +: 8] = wdata_o[8*b +: 8];
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int w, input logic [63:0] v);
        dut_mem[w] = v;
        for (int b = 0; b < 8; b++) ref_mem[8*w + b] = v[8*b +: 8];
    endtask

    task automatic init_mem();
        for (int w = 0; w < NW; w++) set_word(w, {$urandom, $urandom});
    endtask

    function automatic logic [63:0] exp_load(input logic [63:0] addr, input logic [2:0] f3);
        int unsigned size;
        int          bi;
        logic [63:0] v;
        size = 1 << f3[1:0];
        bi   = int'(addr - BASE);
        v    = '0;
        for (int i = 0; i < int'(size); i++) v |= 64'(ref_mem[bi + i]) << (8 * i);
        if (!f3[2] && size < 8 && v[8*size-1]) v |= ~64'h0 << (8 * size);
        return v;
    endfunction

    task automatic drive_req(input bit ld, input logic [2:0] f3, input logic [63:0] addr,
                             input logic [63:0] sd, input logic [4:0] rd);
        req_valid_i = 1'b1;
        is_load_i   = ld;
        is_store_i  = !ld;
        funct3_i    = f3;
        addr_i      = addr;
        st_data_i   = sd;
        rd_waddr_i  = rd;
    endtask

    // One transaction from request to completion, checked against the reference memory
    task automatic do_txn(input bit ld, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] sd, input logic [4:0] rd, output logic [63:0] got);
        int unsigned size, off, beats, want_lat, lat, strobes, k;
        int          bi;
        bit          split, done, saw_mis;
        logic [63:0] expv, al, w;
        size  = 1 << f3[1:0];
        off   = int'(addr[2:0]);
        split = (off + size) > 8;
        beats = split ? 2 : 1;
        al    = addr & ~64'h7;
        bi    = int'(addr - BASE);
        expv  = '0;
        if (ld) begin
            expv     = exp_load(addr, f3);
            want_lat = beats + 2;
        end else begin
            for (int i = 0; i < int'(size); i++) ref_mem[bi + i] = sd[8*i +: 8];
            want_lat = beats + 1;
        end
        drive_req(ld, f3, addr, sd, rd);
        cycle();
        done = 0; saw_mis = 0; lat = 0; strobes = 0; k = 1; got = '0;
        while (k <= 8 && !done) begin
            if (k == 1 || (k == 2 && split)) begin
                n_cmp++;
                if ((ld ? raddr_o : waddr_o) !== al + 64'(8 * (k - 1))) begin
                    n_bad++;
                    $display("FAIL beat%0d_addr: got %h want %h", k, ld ? raddr_o : waddr_o,
                             al + 64'(8 * (k - 1)));
                end
            end
            if (ld ? ren_o : wen_o) strobes++;
            if (misalign_o) saw_mis = 1;
            if (ld && ld_valid_o) begin
                done = 1; lat = k; got = ld_data_o;
                n_cmp++;
                if (ld_rd_o !== rd) begin
                    n_bad++;
                    $display("FAIL ld_rd: got %0d want %0d", ld_rd_o, rd);
                end
            end
            if (!ld && !busy_o) begin
                done = 1; lat = k;
            end
            if (busy_o) begin
                drive_req($urandom_range(0, 1) == 1, 3'($urandom_range(0, 6)),
                          BASE + 64'($urandom_range(0, 255)), {$urandom, $urandom}, 5'($urandom));
            end else begin
                req_valid_i = 1'b0;
            end
            cycle();
            k++;
        end
        req_valid_i = 1'b0;
        n_cmp++;
        if (lat !== want_lat) begin
            n_bad++;
            $display("FAIL latency: got %0d want %0d (ld=%0d f3=%0d addr=%h)", lat, want_lat, ld, f3, addr);
        end
        n_cmp++;
        if (strobes !== beats) begin
            n_bad++;
            $display("FAIL beat_count: got %0d want %0d", strobes, beats);
        end
        n_cmp++;
        if (saw_mis !== 1'b0) begin
            n_bad++;
            $display("FAIL misalign_split1: got 1 want 0");
        end
        if (ld) begin
            n_cmp++;
            if (got !== expv) begin
                n_bad++;
                $display("FAIL ld_data: got %h want %h (f3=%0d addr=%h)", got, expv, f3, addr);
            end
            n_cmp++;
            if (ld_valid_o !== 1'b0 || ld_data_o !== expv) begin
                n_bad++;
                $display("FAIL ld_hold: valid %0d data %h want valid 0 data %h", ld_valid_o, ld_data_o, expv);
            end
        end else begin
            for (int wi = bi / 8; wi < bi / 8 + int'(beats); wi++) begin
                for (int b = 0; b < 8; b++) w[8*b +: 8] = ref_mem[8*wi + b];
                n_cmp++;
                if (dut_mem[wi] !== w) begin
                    n_bad++;
                    $display("FAIL store_mem[%0d]: got %h want %h", wi, dut_mem[wi], w);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid_i = 0; is_load_i = 0; is_store_i = 0; funct3_i = 0;
        addr_i = 0; st_data_i = 0; rd_waddr_i = 0;
        repeat (3) cycle();
        n_cmp++;
        if ({ren_o, wen_o, wmask_o, busy_o, misalign_o, ld_valid_o} !== 12'h0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 0", {ren_o, wen_o, wmask_o, busy_o, misalign_o, ld_valid_o});
        end
        n_cmp++;
        if ({raddr_o, waddr_o, wdata_o} !== 192'h0) begin
            n_bad++;
            $display("FAIL reset_addr_data: got %h %h %h want 0", raddr_o, waddr_o, wdata_o);
        end
        n_cmp++;
        if ({ld_data_o, ld_rd_o} !== 69'h0) begin
            n_bad++;
            $display("FAIL reset_ld: got %h %0d want 0", ld_data_o, ld_rd_o);
        end
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_misalign();
        init_mem();
        drive_req(1, 3'b011, BASE + 64'h4, 64'h0, 5'd3);
        cycle();
        req_valid_i = 1'b0;
        n_cmp++;
        if ({mis0, ren0, wen0} !== 3'b100) begin
            n_bad++;
            $display("FAIL nosplit_t1: got mis/ren/wen %b want 100", {mis0, ren0, wen0});
        end
        n_cmp++;
        if (misalign_o !== 1'b0) begin
            n_bad++;
            $display("FAIL split_mis_t1: got %0d want 0", misalign_o);
        end
        cycle();
        n_cmp++;
        if ({mis0, ren0, wen0, busy0} !== 4'b0000) begin
            n_bad++;
            $display("FAIL nosplit_t2: got mis/ren/wen/busy %b want 0000", {mis0, ren0, wen0, busy0});
        end
        repeat (4) cycle();
    endtask

    task automatic test_directed_loads();
        logic [63:0] got;
        init_mem();
        set_word(0, 64'h8765_4321_0000_0000);
        do_txn(1, 3'b010, BASE + 64'h4, 64'h0, 5'd7, got);
        n_cmp++;
        if (got !== 64'hFFFF_FFFF_8765_4321) begin
            n_bad++;
            $display("FAIL lw_aligned: got %h want ffffffff87654321", got);
        end
        set_word(0, 64'h34CD_CDCD_CDCD_CDCD);
        set_word(1, 64'hCDCD_CDCD_CDCD_CD12);
        do_txn(1, 3'b001, BASE + 64'h7, 64'h0, 5'd9, got);
        n_cmp++;
        if (got !== 64'h1234) begin
            n_bad++;
            $display("FAIL lh_split: got %h want 1234", got);
        end
        set_word(0, 64'hAB00_0000_0000_0000);
        do_txn(1, 3'b100, BASE + 64'h7, 64'h0, 5'd1, got);
        n_cmp++;
        if (got !== 64'hAB) begin
            n_bad++;
            $display("FAIL lbu: got %h want ab", got);
        end
        do_txn(1, 3'b000, BASE + 64'h7, 64'h0, 5'd2, got);
        n_cmp++;
        if (got !== 64'hFFFF_FFFF_FFFF_FFAB) begin
            n_bad++;
            $display("FAIL lb: got %h want ffffffffffffffab", got);
        end
    endtask

    task automatic test_split_store();
        drive_req(0, 3'b011, BASE + 64'h3, 64'h1122_3344_5566_7788, 5'd0);
        cycle();
        req_valid_i = 1'b0;
        n_cmp++;
        if ({wen_o, busy_o, waddr_o, wmask_o, wdata_o} !== {2'b11, BASE, 8'hF8, 64'h4455_6677_8800_0000}) begin
            n_bad++;
            $display("FAIL sd_beat0: got wen %0d busy %0d addr %h mask %h data %h", wen_o, busy_o, waddr_o, wmask_o, wdata_o);
        end
        cycle();
        n_cmp++;
        if ({wen_o, busy_o, waddr_o, wmask_o, wdata_o} !== {2'b11, BASE + 64'h8, 8'h07, 64'h0000_0000_0011_2233}) begin
            n_bad++;
            $display("FAIL sd_beat1: got wen %0d busy %0d addr %h mask %h data %h", wen_o, busy_o, waddr_o, wmask_o, wdata_o);
        end
        cycle();
        n_cmp++;
        if ({wen_o, busy_o, wmask_o} !== 10'h0) begin
            n_bad++;
            $display("FAIL sd_end: got wen %0d busy %0d mask %h want 0", wen_o, busy_o, wmask_o);
        end
    endtask

    task automatic test_invalid();
        logic [6:0] pat [4];
        pat[0] = {1'b1, 1'b1, 1'b0, 3'b111, 1'b0};
        pat[1] = {1'b1, 1'b1, 1'b1, 3'b010, 1'b0};
        pat[2] = {1'b1, 1'b0, 1'b0, 3'b010, 1'b0};
        pat[3] = {1'b0, 1'b1, 1'b0, 3'b010, 1'b0};
        for (int p = 0; p < 4; p++) begin
            req_valid_i = pat[p][6];
            is_load_i   = pat[p][5];
            is_store_i  = pat[p][4];
            funct3_i    = pat[p][3:1];
            addr_i      = BASE + 64'h10;
            cycle();
            req_valid_i = 1'b0;
            for (int c = 0; c < 3; c++) begin
                n_cmp++;
                if ({ren_o, wen_o, busy_o} !== 3'b000) begin
                    n_bad++;
                    $display("FAIL invalid_req%0d: got ren/wen/busy %b want 000", p, {ren_o, wen_o, busy_o});
                end
                cycle();
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] e1, e2;
        init_mem();
        e1 = exp_load(BASE + 64'h10, 3'b011);
        e2 = exp_load(BASE + 64'h24, 3'b010);
        drive_req(1, 3'b011, BASE + 64'h10, 64'h0, 5'd4);
        cycle();
        req_valid_i = 1'b0;
        repeat (2) cycle();
        n_cmp++;
        if ({ld_valid_o, ld_data_o} !== {1'b1, e1}) begin
            n_bad++;
            $display("FAIL b2b_first: got valid %0d data %h want 1 %h", ld_valid_o, ld_data_o, e1);
        end
        drive_req(1, 3'b010, BASE + 64'h24, 64'h0, 5'd5);
        cycle();
        req_valid_i = 1'b0;
        n_cmp++;
        if ({busy_o, ren_o, raddr_o} !== {2'b11, BASE + 64'h20}) begin
            n_bad++;
            $display("FAIL b2b_accept: got busy %0d ren %0d addr %h", busy_o, ren_o, raddr_o);
        end
        repeat (2) cycle();
        n_cmp++;
        if ({ld_valid_o, ld_data_o, ld_rd_o} !== {1'b1, e2, 5'd5}) begin
            n_bad++;
            $display("FAIL b2b_second: got valid %0d data %h rd %0d want 1 %h 5", ld_valid_o, ld_data_o, ld_rd_o, e2);
        end
        cycle();
    endtask

    task automatic test_random();
        logic [63:0] got;
        init_mem();
        for (int n = 0; n < 150; n++) begin
            do_txn($urandom_range(0, 1) == 1, 3'($urandom_range(0, 6)),
                   BASE + 64'($urandom_range(0, 255)), {$urandom, $urandom},
                   5'($urandom), got);
        end
    endtask

    task automatic test_reset_mid();
        drive_req(1, 3'b011, BASE + 64'h4, 64'h0, 5'd6);
        cycle();
        req_valid_i = 1'b0;
        n_cmp++;
        if (ren_o !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_t1: got ren %0d want 1", ren_o);
        end
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_cmp++;
        if ({ren_o, wen_o, raddr_o, waddr_o, wdata_o, wmask_o, busy_o, misalign_o,
             ld_valid_o, ld_data_o, ld_rd_o} !== '0) begin
            n_bad++;
            $display("FAIL rstmid_t3: got ren %0d wen %0d raddr %h busy %0d ldv %0d ldd %h rd %0d want all 0",
                     ren_o, wen_o, raddr_o, busy_o, ld_valid_o, ld_data_o, ld_rd_o);
        end
        for (int c = 0; c < 5; c++) begin
            cycle();
            n_cmp++;
            if ({ld_valid_o, ren_o, busy_o} !== 3'b000) begin
                n_bad++;
                $display("FAIL rstmid_after%0d: got ldv/ren/busy %b want 000", c, {ld_valid_o, ren_o, busy_o});
            end
        end
    endtask

    initial begin
        test_reset();
        test_misalign();
        test_directed_loads();
        test_split_store();
        test_invalid();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
